// File: rtl/round_pack_sum.sv
// round_pack_sum: two-stage round-to-nearest-even and IEEE-754 single pack.
// S1 rounds the normalised mantissa (GRS) and pre-computes the flush flag.
// S2 packs the result, saturating to infinity and flushing to signed zero.
// Idle words bypass both operations and carry their sout word unchanged.
// Optional build macro ROUND_PACK_STATUS_EN adds the inexact_Pack and
// overflow_Pack outputs, which stay aligned with out_valid.
module round_pack_sum #(
   parameter int TAG_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             idle_NormaliseSum,
   input  logic [31:0]      sout_NormaliseSum,
   input  logic [27:0]      sum_NormaliseSum,
   input  logic [3:0]       Opcode_NormaliseSum,
   input  logic [31:0]      z_postNormaliseSum,
   input  logic [TAG_W-1:0] InsTagNormaliseAdder,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             idle_Pack,
   output logic [31:0]      sout_Pack,
   output logic [3:0]       Opcode_Pack,
   output logic [31:0]      z_postPack,
   output logic [TAG_W-1:0] InsTagPack
`ifdef ROUND_PACK_STATUS_EN
   ,
   output logic             inexact_Pack,
   output logic             overflow_Pack
`endif
);

   logic             s1_valid_q, s1_valid_d;
   logic             s1_idle_q, s1_idle_d;
   logic [31:0]      s1_sout_q, s1_sout_d;
   logic [8:0]       s1_exp_q, s1_exp_d;
   logic [22:0]      s1_mant_q, s1_mant_d;
   logic             s1_zero_q, s1_zero_d;
   logic [3:0]       s1_op_q, s1_op_d;
   logic [31:0]      s1_z_q, s1_z_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic             s2_valid_q, s2_valid_d;
   logic             idle_pack_q, idle_pack_d;
   logic [31:0]      sout_pack_q, sout_pack_d;
   logic [3:0]       op_pack_q, op_pack_d;
   logic [31:0]      z_pack_q, z_pack_d;
   logic [TAG_W-1:0] tag_pack_q, tag_pack_d;

   logic             s1_adv, accept, round_inc;
   logic [23:0]      mant_in;
   logic [24:0]      mant_rnd;
   logic [31:0]      pack_word;
   logic             pack_ovf;

`ifdef ROUND_PACK_STATUS_EN
   logic             s1_inexact_q, s1_inexact_d;
   logic             inexact_pack_q, inexact_pack_d;
   logic             overflow_pack_q, overflow_pack_d;
`endif

   // Handshake: S1 may move on when S2 is empty or draining this cycle.
   always_comb begin
      s1_adv   = !s2_valid_q || out_ready;
      in_ready = !s1_valid_q || s1_adv;
      accept   = in_valid && in_ready;
   end

   // S1 next state: round-to-nearest-even with carry-out renormalisation.
   always_comb begin
      mant_in   = sum_NormaliseSum[26:3];
      round_inc = sum_NormaliseSum[2] &&
                  (sum_NormaliseSum[1] || sum_NormaliseSum[0] || mant_in[0]);
      mant_rnd  = {1'b0, mant_in} + {24'd0, round_inc};

      s1_valid_d = s1_valid_q;
      s1_idle_d  = s1_idle_q;
      s1_sout_d  = s1_sout_q;
      s1_exp_d   = s1_exp_q;
      s1_mant_d  = s1_mant_q;
      s1_zero_d  = s1_zero_q;
      s1_op_d    = s1_op_q;
      s1_z_d     = s1_z_q;
      s1_tag_d   = s1_tag_q;
`ifdef ROUND_PACK_STATUS_EN
      s1_inexact_d = s1_inexact_q;
`endif
      if (in_ready) s1_valid_d = accept;
      if (accept) begin
         s1_idle_d = idle_NormaliseSum;
         s1_sout_d = sout_NormaliseSum;
         s1_zero_d = (mant_in == 24'd0) || (sout_NormaliseSum[30:23] == 8'd0);
         s1_op_d   = Opcode_NormaliseSum;
         s1_z_d    = z_postNormaliseSum;
         s1_tag_d  = InsTagNormaliseAdder;
         if (mant_rnd[24]) begin
            s1_mant_d = 23'd0;
            s1_exp_d  = {1'b0, sout_NormaliseSum[30:23]} + 9'd1;
         end else begin
            s1_mant_d = mant_rnd[22:0];
            s1_exp_d  = {1'b0, sout_NormaliseSum[30:23]};
         end
`ifdef ROUND_PACK_STATUS_EN
         s1_inexact_d = !idle_NormaliseSum && (sum_NormaliseSum[2:0] != 3'd0);
`endif
      end
   end

   // S2 pack: flush-to-zero wins over infinity, idle bypasses both.
   always_comb begin
      pack_ovf = 1'b0;
      if (s1_idle_q)
         pack_word = s1_sout_q;
      else if (s1_zero_q)
         pack_word = {s1_sout_q[31], 31'd0};
      else if (s1_exp_q >= 9'd255) begin
         pack_word = {s1_sout_q[31], 8'hFF, 23'd0};
         pack_ovf  = 1'b1;
      end else
         pack_word = {s1_sout_q[31], s1_exp_q[7:0], s1_mant_q};

      s2_valid_d  = s2_valid_q;
      idle_pack_d = idle_pack_q;
      sout_pack_d = sout_pack_q;
      op_pack_d   = op_pack_q;
      z_pack_d    = z_pack_q;
      tag_pack_d  = tag_pack_q;
`ifdef ROUND_PACK_STATUS_EN
      inexact_pack_d  = inexact_pack_q;
      overflow_pack_d = overflow_pack_q;
`endif
      if (s1_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            idle_pack_d = s1_idle_q;
            sout_pack_d = pack_word;
            op_pack_d   = s1_op_q;
            z_pack_d    = s1_z_q;
            tag_pack_d  = s1_tag_q;
`ifdef ROUND_PACK_STATUS_EN
            inexact_pack_d  = s1_inexact_q;
            overflow_pack_d = pack_ovf;
`endif
         end
      end
   end

   // Pipeline registers; reset empties both stages and clears the outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_idle_q   <= 1'b0;
         s1_sout_q   <= '0;
         s1_exp_q    <= '0;
         s1_mant_q   <= '0;
         s1_zero_q   <= 1'b0;
         s1_op_q     <= '0;
         s1_z_q      <= '0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         idle_pack_q <= 1'b0;
         sout_pack_q <= '0;
         op_pack_q   <= '0;
         z_pack_q    <= '0;
         tag_pack_q  <= '0;
`ifdef ROUND_PACK_STATUS_EN
         s1_inexact_q    <= 1'b0;
         inexact_pack_q  <= 1'b0;
         overflow_pack_q <= 1'b0;
`endif
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_idle_q   <= s1_idle_d;
         s1_sout_q   <= s1_sout_d;
         s1_exp_q    <= s1_exp_d;
         s1_mant_q   <= s1_mant_d;
         s1_zero_q   <= s1_zero_d;
         s1_op_q     <= s1_op_d;
         s1_z_q      <= s1_z_d;
         s1_tag_q    <= s1_tag_d;
         s2_valid_q  <= s2_valid_d;
         idle_pack_q <= idle_pack_d;
         sout_pack_q <= sout_pack_d;
         op_pack_q   <= op_pack_d;
         z_pack_q    <= z_pack_d;
         tag_pack_q  <= tag_pack_d;
`ifdef ROUND_PACK_STATUS_EN
         s1_inexact_q    <= s1_inexact_d;
         inexact_pack_q  <= inexact_pack_d;
         overflow_pack_q <= overflow_pack_d;
`endif
      end
   end

   assign out_valid   = s2_valid_q;
   assign idle_Pack   = idle_pack_q;
   assign sout_Pack   = sout_pack_q;
   assign Opcode_Pack = op_pack_q;
   assign z_postPack  = z_pack_q;
   assign InsTagPack  = tag_pack_q;
`ifdef ROUND_PACK_STATUS_EN
   assign inexact_Pack  = inexact_pack_q;
   assign overflow_Pack = overflow_pack_q;
`endif

endmodule

// File: tb/tb_round_pack_sum.sv
// Scoreboard bench for round_pack_sum: the driver pushes hand-computed
// expected words when the DUT accepts, the monitor pops on each output beat.
module tb_round_pack_sum;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        idle_in = 1'b0;
   logic [31:0] sout_in = '0;
   logic [27:0] sum_in = '0;
   logic [3:0]  op_in = '0;
   logic [31:0] z_in = '0;
   logic [7:0]  tag_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        idle_Pack;
   logic [31:0] sout_Pack;
   logic [3:0]  Opcode_Pack;
   logic [31:0] z_postPack;
   logic [7:0]  InsTagPack;
`ifdef ROUND_PACK_STATUS_EN
   logic        inexact_Pack;
   logic        overflow_Pack;
`endif

   typedef struct packed {
      logic        idle;
      logic [31:0] sout;
      logic [3:0]  op;
      logic [31:0] z;
      logic [7:0]  tag;
   } word_t;

   word_t sb[$];
   int    checks = 0;
   int    errors = 0;
   bit    saw_block = 1'b0;
   bit    held = 1'b0;
   word_t held_word;

   always #5 clock = ~clock;

   round_pack_sum #(.TAG_W(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .idle_NormaliseSum(idle_in), .sout_NormaliseSum(sout_in),
      .sum_NormaliseSum(sum_in), .Opcode_NormaliseSum(op_in),
      .z_postNormaliseSum(z_in), .InsTagNormaliseAdder(tag_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .idle_Pack(idle_Pack), .sout_Pack(sout_Pack),
      .Opcode_Pack(Opcode_Pack), .z_postPack(z_postPack),
      .InsTagPack(InsTagPack)
`ifdef ROUND_PACK_STATUS_EN
      , .inexact_Pack(inexact_Pack), .overflow_Pack(overflow_Pack)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Drive one word; push the expected output once the DUT will take it.
   task automatic send(input logic idl, input logic [31:0] so, input logic [27:0] sm,
                       input logic [7:0] tg, input logic [31:0] ex);
      word_t w;
      int n;
      @(negedge clock);
      idle_in = idl; sout_in = so; sum_in = sm; tag_in = tg;
      op_in = tg[3:0]; z_in = {24'hA5C3E1, tg};
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stuck 0 for tag %h", tg);
      end else begin
         w.idle = idl; w.sout = ex; w.op = tg[3:0]; w.z = {24'hA5C3E1, tg}; w.tag = tg;
         sb.push_back(w);
      end
      @(posedge clock);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: compare each output beat against the scoreboard head.
   always @(negedge clock) begin
      word_t act;
      act = '{idle: idle_Pack, sout: sout_Pack, op: Opcode_Pack, z: z_postPack, tag: InsTagPack};
      if (reset_n && in_valid && !in_ready) saw_block = 1'b1;
      if (reset_n && held && out_valid)
         check("hold_stable", 64'(act[76:13]), 64'(held_word[76:13]));
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: tag %h sout %h with nothing expected", InsTagPack, sout_Pack);
         end else begin
            word_t e;
            e = sb.pop_front();
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL out_word tag %h: got idle=%b sout=%h op=%h z=%h tag=%h expected idle=%b sout=%h op=%h z=%h tag=%h",
                        e.tag, act.idle, act.sout, act.op, act.z, act.tag,
                        e.idle, e.sout, e.op, e.z, e.tag);
            end
         end
      end
      held = reset_n && out_valid && !out_ready;
      held_word = act;
   end

   initial begin
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_sout", 64'(sout_Pack), 64'd0);
      check("rst_tag_idle", 64'({InsTagPack, idle_Pack}), 64'd0);
      #20 reset_n = 1'b1;

      // Plain 1.0 with latency check.
      send(1'b0, 32'h3F800000, 28'h4000000, 8'h10, 32'h3F800000);
      check("lat_cycle1", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
      check("lat_cycle2", 64'(out_valid), 64'd1);
      drain();

      // Directed rounding / packing vectors.
      send(1'b0, 32'h3F800000, 28'h4000004, 8'h11, 32'h3F800000); // tie, even stays
      send(1'b0, 32'h3F800000, 28'h400000C, 8'h12, 32'h3F800002); // tie, odd rounds up
      send(1'b0, 32'h3F800000, 28'h400001C, 8'h13, 32'h3F800004); // tie, 3 -> 4
      send(1'b0, 32'h3F800000, 28'h400000B, 8'h14, 32'h3F800001); // guard 0, no round
      send(1'b0, 32'h3F800000, 28'h7FFFFFE, 8'h15, 32'h40000000); // carry-out
      send(1'b0, 32'h7F000000, 28'h7FFFFFE, 8'h16, 32'h7F800000); // overflow to inf
      send(1'b0, 32'hC0000000, 28'h4000005, 8'h17, 32'hC0000001); // negative, round up
      send(1'b0, 32'h80000000, 28'h4000000, 8'h18, 32'h80000000); // exp 0 flush
      send(1'b0, 32'h3F800000, 28'h0000000, 8'h19, 32'h00000000); // zero mantissa
      send(1'b1, 32'hDEADBEEF, 28'h7FFFFFF, 8'h5A, 32'hDEADBEEF); // idle bypass
      drain();

      // Back-to-back stream with a downstream stall.
      fork
         begin
            for (int t = 1; t <= 6; t++)
               send(1'b0, 32'h3F800000, 28'h4000000 | (28'(t) << 3), 8'(t),
                    32'h3F800000 | 32'(t));
         end
         begin
            repeat (3) @(posedge clock);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clock);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("stream_in_ready_dropped", 64'(saw_block), 64'd1);

      // Reset with two words in flight.
      @(posedge clock); #1 out_ready = 1'b0;
      send(1'b0, 32'h3F800000, 28'h4000008, 8'h21, 32'h3F800001);
      send(1'b0, 32'h3F800000, 28'h4000010, 8'h22, 32'h3F800002);
      #2 reset_n = 1'b0;
      sb.delete();
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_sout", 64'(sout_Pack), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clock);
      reset_n = 1'b1;
      out_ready = 1'b1;
      send(1'b0, 32'h40000000, 28'h4000000, 8'h30, 32'h40000000);
      check("post_rst_lat1", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
      check("post_rst_lat2", 64'({out_valid, InsTagPack}), 64'h130);
      drain();
      repeat (5) @(negedge clock);
      check("post_rst_idle", 64'(out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
